// File: rtl/fpmult_unpack_module_if.sv
// Operand/result handshake bundle for the multiplier front-end unpacker.
// The slave modport is the unpacker's view; master is the source/consumer side.
interface fpmult_unpack_module_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic        sa;
  logic        sb;
  logic        sgn;
  logic [8:0]  ea;
  logic [8:0]  eb;
  logic [23:0] ma;
  logic [23:0] mb;
  logic [3:0]  ca;
  logic [3:0]  cb;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sa, sb, sgn, ea, eb, ma, mb, ca, cb
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sa, sb, sgn, ea, eb, ma, mb, ca, cb
  );
endinterface

// File: rtl/fpmult_unpack_module.sv
// Two-stage unpacker: S1 captures raw IEEE-754 operands, S2 holds decoded
// sign/exponent/mantissa/class fields and drives the outputs.
module fpmult_unpack_module #(
  parameter bit FLUSH_DENORM = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  fpmult_unpack_module_if.slave bus
);

  typedef struct packed {
    logic        s;
    logic [8:0]  e;
    logic [23:0] m;
    logic [3:0]  c;   // [0] zero, [1] denormal, [2] infinity, [3] NaN
  } fieldT;

  function automatic fieldT decode(input logic [31:0] x);
    fieldT      f;
    logic [7:0] ex;
    logic [22:0] fr;
    ex  = x[30:23];
    fr  = x[22:0];
    f.s = x[31];
    f.e = {1'b0, ex};
    f.m = {1'b1, fr};
    f.c = 4'b0000;
    if (ex == 8'hFF) begin
      f.c = (fr == 23'd0) ? 4'b0100 : 4'b1000;
    end else if (ex == 8'h00) begin
      if (fr == 23'd0) begin
        f.e = 9'd0;
        f.m = 24'd0;
        f.c = 4'b0001;
      end else if (FLUSH_DENORM) begin
        f.e = 9'd0;
        f.m = 24'd0;
        f.c = 4'b0011;
      end else begin
        // Denormals carry the true exponent 1 with no hidden bit.
        f.e = 9'd1;
        f.m = {1'b0, fr};
        f.c = 4'b0010;
      end
    end
    return f;
  endfunction

  logic        s1Valid;
  logic [31:0] s1A;
  logic [31:0] s1B;
  logic        s2Valid;
  fieldT       s2A;
  fieldT       s2B;
  logic        s1Load;
  logic        s2Load;
  logic        inReady;

  // NOTE: combinational blocks assign every output unconditionally so no latch is inferred.
  always_comb begin
    s2Load  = s1Valid && (!s2Valid || bus.out_ready);
    inReady = !s1Valid || s2Load;
    s1Load  = bus.in_valid && inReady;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are cleared too, because the outputs must read zero after reset.
      s1Valid <= 1'b0;
      s1A     <= '0;
      s1B     <= '0;
      s2Valid <= 1'b0;
      s2A     <= '0;
      s2B     <= '0;
    end else begin
      if (s1Load) begin
        s1A <= bus.a;
        s1B <= bus.b;
      end
      s1Valid <= s1Load || (s1Valid && !s2Load);
      if (s2Load) begin
        s2A <= decode(s1A);
        s2B <= decode(s1B);
      end
      s2Valid <= s2Load || (s2Valid && !bus.out_ready);
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = s2Valid;
  assign bus.sa        = s2A.s;
  assign bus.sb        = s2B.s;
  assign bus.sgn       = s2A.s ^ s2B.s;
  assign bus.ea        = s2A.e;
  assign bus.eb        = s2B.e;
  assign bus.ma        = s2A.m;
  assign bus.mb        = s2B.m;
  assign bus.ca        = s2A.c;
  assign bus.cb        = s2B.c;

endmodule

// File: tb/tb_fpmult_unpack_module.sv
// Bench for fpmult_unpack_module: one flushing and one pass-through instance share
// stimulus; a queue-based scoreboard with a rule-level decode model checks both.
module tb_fpmult_unpack_module;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpmult_unpack_module_if bus0 ();
  fpmult_unpack_module_if bus1 ();

  fpmult_unpack_module #(.FLUSH_DENORM(1'b1)) dutFlush (.clk(clk), .rst(rst), .bus(bus0));
  fpmult_unpack_module #(.FLUSH_DENORM(1'b0)) dutPass  (.clk(clk), .rst(rst), .bus(bus1));

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.a         = bus0.a;
  assign bus1.b         = bus0.b;
  assign bus1.out_ready = bus0.out_ready;

  logic [76:0] out0, out1;
  assign out0 = {bus0.sa, bus0.sb, bus0.sgn, bus0.ea, bus0.eb, bus0.ma, bus0.mb, bus0.ca, bus0.cb};
  assign out1 = {bus1.sa, bus1.sb, bus1.sgn, bus1.ea, bus1.eb, bus1.ma, bus1.mb, bus1.ca, bus1.cb};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode: {e[8:0], m[23:0], class[3:0]} from the IEEE-754 field rules.
  function automatic logic [36:0] refField(input logic [31:0] x, input bit flush);
    int expo;
    int frac;
    expo = int'(x[30:23]);
    frac = int'(x[22:0]);
    if (expo == 255) return {9'd255, 1'b1, x[22:0], (frac == 0) ? 4'b0100 : 4'b1000};
    if (expo == 0 && frac == 0) return {9'd0, 24'd0, 4'b0001};
    if (expo == 0) return flush ? {9'd0, 24'd0, 4'b0011} : {9'd1, 24'(frac), 4'b0010};
    return {9'(expo), 24'(frac + (1 << 23)), 4'b0000};
  endfunction

  function automatic logic [76:0] expVec(input logic [31:0] a, input logic [31:0] b, input bit flush);
    logic [36:0] fa;
    logic [36:0] fb;
    fa = refField(a, flush);
    fb = refField(b, flush);
    return {a[31], b[31], a[31] ^ b[31], fa[36:28], fb[36:28], fa[27:4], fb[27:4], fa[3:0], fb[3:0]};
  endfunction

  // Scoreboard: every accepted pair must come out once, in order.
  logic [63:0] q[$];
  int          pops = 0;
  bit          prevStall = 1'b0;
  logic [76:0] prevOut0, prevOut1;

  always @(negedge clk) begin
    logic [63:0] p;
    if (rst) begin
      q.delete();
      prevStall = 1'b0;
    end else begin
      check("in_ready", {bus0.in_ready, bus1.in_ready},
            {2{(q.size() < 2) || bus0.out_ready}});
      if (prevStall) check("hold", {out0, out1}, {prevOut0, prevOut1});
      if (bus0.out_valid && q.size() == 0) check("spurious_valid", 1, 0);
      if (bus0.out_valid && bus0.out_ready && q.size() != 0) begin
        p = q.pop_front();
        check("stream", {out0, out1},
              {expVec(p[63:32], p[31:0], 1'b1), expVec(p[63:32], p[31:0], 1'b0)});
        pops++;
      end
      if (bus0.in_valid && bus0.in_ready) q.push_back({bus0.a, bus0.b});
      prevStall = bus0.out_valid && !bus0.out_ready;
      prevOut0  = out0;
      prevOut1  = out1;
    end
  end

  typedef struct {
    logic [31:0] a, b;
    bit          flush;
    logic        sa, sb;
    logic [8:0]  ea, eb;
    logic [23:0] ma, mb;
    logic [3:0]  ca, cb;
  } vecT;

  vecT vecs[6];

  function automatic logic [31:0] randOperand();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 5))
      0: x[30:0] = 31'd0;
      1: x[30:23] = 8'd0;
      2: x[30:0] = {8'hFF, 23'd0};
      3: x[30:23] = 8'hFF;
      default: ;
    endcase
    return x;
  endfunction

  task automatic drain();
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    int  popBase;
    int  idx;
    int  runCount;
    bit  sawBlock;
    logic [31:0] streamA[8];
    logic [31:0] streamB[8];

    vecs[0] = '{32'h3F800000, 32'h40000000, 1'b1, 1'b0, 1'b0, 9'h07F, 9'h080, 24'h800000, 24'h800000, 4'b0000, 4'b0000};
    vecs[1] = '{32'h7F800000, 32'hFFC00000, 1'b1, 1'b0, 1'b1, 9'h0FF, 9'h0FF, 24'h800000, 24'hC00000, 4'b0100, 4'b1000};
    vecs[2] = '{32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b1, 9'h000, 9'h000, 24'h000000, 24'h000000, 4'b0011, 4'b0001};
    vecs[3] = '{32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 9'h001, 9'h000, 24'h000001, 24'h000000, 4'b0010, 4'b0001};
    vecs[4] = '{32'h807FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 1'b0, 9'h001, 9'h0FE, 24'h7FFFFF, 24'hFFFFFF, 4'b0010, 4'b0000};
    vecs[5] = '{32'h7F800001, 32'h00800000, 1'b1, 1'b0, 1'b0, 9'h0FF, 9'h001, 24'h800001, 24'h800000, 4'b1000, 4'b0000};

    bus0.in_valid  = 1'b0;
    bus0.a         = '0;
    bus0.b         = '0;
    bus0.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", {bus0.out_valid, bus1.out_valid}, 2'b00);
    check("reset_ready", {bus0.in_ready, bus1.in_ready}, 2'b11);
    check("reset_fields", {out0, out1}, '0);

    // Directed vectors: single pair, output visible two cycles after presentation.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      bus0.in_valid  = 1'b1;
      bus0.a         = vecs[i].a;
      bus0.b         = vecs[i].b;
      bus0.out_ready = 1'b1;
      @(posedge clk);
      #1 bus0.in_valid = 1'b0;
      @(negedge clk);
      check("vec_early", bus0.out_valid, 1'b0);
      @(negedge clk);
      check("vec_valid", bus0.out_valid, 1'b1);
      check("vec_fields", vecs[i].flush ? out0 : out1,
            {vecs[i].sa, vecs[i].sb, vecs[i].sa ^ vecs[i].sb, vecs[i].ea, vecs[i].eb,
             vecs[i].ma, vecs[i].mb, vecs[i].ca, vecs[i].cb});
    end
    drain();

    // Eight back-to-back pairs with the consumer stalled in cycles 3-6.
    for (int i = 0; i < 8; i++) begin
      streamA[i] = randOperand();
      streamB[i] = randOperand();
    end
    popBase  = pops;
    idx      = 0;
    sawBlock = 1'b0;
    for (int c = 0; c < 100 && idx < 8; c++) begin
      @(posedge clk);
      #1;
      bus0.in_valid  = 1'b1;
      bus0.a         = streamA[idx];
      bus0.b         = streamB[idx];
      bus0.out_ready = !(c >= 3 && c <= 6);
      @(negedge clk);
      if (!bus0.in_ready) sawBlock = 1'b1;
      if (bus0.in_ready) idx++;
    end
    @(posedge clk);
    #1 bus0.in_valid = 1'b0;
    drain();
    check("stall_blocked", sawBlock, 1'b1);
    check("stall_count", pops - popBase, 8);

    // Full-rate random stream.
    popBase  = pops;
    runCount = 0;
    for (int i = 0; i < 102; i++) begin
      @(posedge clk);
      #1;
      bus0.out_ready = 1'b1;
      bus0.in_valid  = (i < 100);
      bus0.a         = randOperand();
      bus0.b         = randOperand();
      @(negedge clk);
      if (i >= 2 && bus0.out_valid) runCount++;
    end
    @(posedge clk);
    #1 bus0.in_valid = 1'b0;
    drain();
    check("rate_cycles", runCount, 100);
    check("rate_count", pops - popBase, 100);

    // Reset with two pairs in flight and the consumer stalled.
    @(posedge clk);
    #1;
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.a         = 32'h40490FDB;
    bus0.b         = 32'hC0000000;
    @(posedge clk);
    #1;
    bus0.a = 32'h3F000000;
    bus0.b = 32'h00400000;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("full_ready", bus0.in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst            = 1'b1;
    bus0.out_ready = 1'b1;
    bus0.a         = 32'h12345678;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus0.in_valid = 1'b0;
    @(negedge clk);
    check("rst_valid", {bus0.out_valid, bus1.out_valid}, 2'b00);
    check("rst_ready", {bus0.in_ready, bus1.in_ready}, 2'b11);
    check("rst_fields", {out0, out1}, '0);
    popBase = pops;
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b1;
    bus0.a        = 32'hBF800000;
    bus0.b        = 32'h00000003;
    @(posedge clk);
    #1 bus0.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_valid", bus0.out_valid, 1'b1);
    drain();
    check("post_rst_count", pops - popBase, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
